// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the per-pipe motion
//               controller: FSM state encoding, datapath widths, LFSR taps
//               and the gap-range mapping helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Pipe lifecycle states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MOVE = 2'd2,
    S_DONE = 2'd3
  } pipe_state_t;

  // Horizontal position and gap row widths
  localparam int X_W   = 11;
  localparam int GAP_W = 10;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Fold a 9-bit random value into GAP_MIN..GAP_MAX. The span is at least
  // 255, so a single conditional subtract of (span+1) always lands in range.
  function automatic logic [GAP_W-1:0] gap_map(
    input logic [8:0] r,
    input int         gap_min,
    input int         gap_max
  );
    logic [9:0] span;
    logic [9:0] off;
    span = 10'(gap_max - gap_min);
    if ({1'b0, r} > span) begin
      off = {1'b0, r} - span - 10'd1;
    end else begin
      off = {1'b0, r};
    end
    return GAP_W'(gap_min) + off;
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : pipe_lfsr
// Description : Free-running 16-bit Galois LFSR. Each pipe instance gets its
//               own seed so the three pipes produce independent gap streams.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_lfsr
  import pipe_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  output logic [15:0] o_State
);

  logic [15:0] state_d;
  logic [15:0] state_q;

  // Next LFSR value: shift right, apply taps when the outgoing bit is set
  always_comb begin
    state_d = {1'b0, state_q[15:1]};
    if (state_q[0]) begin
      state_d = state_d ^ LFSR_TAPS;
    end
  end

  // LFSR register, advances every clock
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign o_State = state_q;

endmodule : pipe_lfsr
`default_nettype wire

// File: rtl/pipe_mover.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mover
// Description : Per-pipe motion controller. A start pulse loads the pipe just
//               off the right edge of the screen, then the right-edge column
//               steps left by one pixel every MOVE_DIV cycles until it reaches
//               zero. Emits a pass pulse as the pipe clears the bird column
//               and a done pulse when the pipe has left the screen.
//               Build option PIPE_RANDOM_GAP_EN: when defined, the gap row is
//               drawn from a per-instance LFSR at load time; otherwise the
//               gap is fixed at the midpoint of GAP_MIN..GAP_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mover
  import pipe_pkg::*;
#(
  parameter int          SCREEN_W  = 640,
  parameter int          PIPE_W    = 64,
  parameter int          GAP_MIN   = 40,
  parameter int          GAP_MAX   = 320,
  parameter int          MOVE_DIV  = 416667,
  parameter int          BIRD_X    = 160,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic             i_Freeze,
  output logic [X_W-1:0]   o_X_Right,
  output logic [GAP_W-1:0] o_Gap_Top,
  output logic             o_Active,
  output logic             o_Passed,
  output logic             o_Done
);

  // Step counter just wide enough for 0..MOVE_DIV-1
  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MOVE_DIV - 1);
  localparam logic [X_W-1:0]   c_x_start  = X_W'(SCREEN_W + PIPE_W);
  localparam logic [X_W-1:0]   c_x_bird   = X_W'(BIRD_X);

  pipe_state_t      state_d,  state_q;
  logic [X_W-1:0]   x_d,      x_q;
  logic [CNT_W-1:0] cnt_d,    cnt_q;
  logic             passed_d, passed_q;
  logic             active_d, active_q;
  logic             done_d,   done_q;

`ifdef PIPE_RANDOM_GAP_EN
  logic [GAP_W-1:0] gap_d, gap_q;
  logic [15:0]      lfsr_state;
  logic [6:0]       lfsr_unused;

  // Only the low nine bits feed the gap mapping
  assign lfsr_unused = lfsr_state[15:9];

  pipe_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .o_State (lfsr_state)
  );
`else
  localparam logic [GAP_W-1:0] c_gap_mid   = GAP_W'((GAP_MIN + GAP_MAX) / 2);
  localparam logic [15:0]      c_seed_unused = LFSR_SEED;
`endif

  // Next-state, position, step counter and pulse generation
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    cnt_d    = cnt_q;
    passed_d = 1'b0;
`ifdef PIPE_RANDOM_GAP_EN
    gap_d    = gap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        x_d     = c_x_start;
        cnt_d   = '0;
`ifdef PIPE_RANDOM_GAP_EN
        gap_d   = gap_map(lfsr_state[8:0], GAP_MIN, GAP_MAX);
`endif
        state_d = S_MOVE;
      end
      S_MOVE: begin
        // Freeze holds counter and position; no step means no pulses
        if (!i_Freeze) begin
          if (cnt_q == c_cnt_last) begin
            cnt_d = '0;
            // Position never underflows below zero
            if (x_q != '0) begin
              x_d = x_q - X_W'(1);
              if (x_q == c_x_bird) begin
                passed_d = 1'b1;
              end
              if (x_q == X_W'(1)) begin
                state_d = S_DONE;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs registered from the upcoming state
  always_comb begin
    active_d = (state_d == S_LOAD) || (state_d == S_MOVE);
    done_d   = (state_d == S_DONE);
  end

  // Main register bank; reset always returns the pipe to idle at column 0
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      cnt_q    <= '0;
      passed_q <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      cnt_q    <= cnt_d;
      passed_q <= passed_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

`ifdef PIPE_RANDOM_GAP_EN
  // Gap row latched at load time from the LFSR
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      gap_q <= GAP_W'(GAP_MIN);
    end else begin
      gap_q <= gap_d;
    end
  end

  assign o_Gap_Top = gap_q;
`else
  assign o_Gap_Top = c_gap_mid;
`endif

  assign o_X_Right = x_q;
  assign o_Active  = active_q;
  assign o_Passed  = passed_q;
  assign o_Done    = done_q;

endmodule : pipe_mover
`default_nettype wire
